spi_bus_arbiter: RTL and testbench
==================================

// Module: spi_bus_arbiter
// PURPOSE
//  Shares the single board SPI bus (spi_clk/spi_mosi/spi_miso plus device selects for MMC, flash, RTC)
//  between two byte-level clients: client 0 = host control CPU (cfide side), client 1 = Amiga-side SPI.
//  Round-robin arbitration per transaction, optional bus lock for multi-byte frames, SPI mode 0 shifter.
//  Sits between the control/Minimig SPI requesters and the top-level SPI pins.
// PARAMETERS
//  CLK_DIV   4  sysclk cycles per spi_clk half-period (>=1)
//  CS_SETUP  2  sysclk cycles from select assertion to first spi_clk rising edge (>=1)
//  NUM_DEV   3  number of device selects (0=MMC, 1=flash, 2=RTC)
// PORTS
//  sysclk      in   1        system clock; all logic on rising edge
//  n_reset     in   1        synchronous, active-low reset
//  req[1:0]    in   2        per-client transfer request; held high until ack
//  lock[1:0]   in   2        per-client: keep select asserted and bus owned after current byte
//  dev0, dev1  in   2 each   device index for client 0 / 1 (sampled at grant)
//  tx0, tx1    in   8 each   byte to send (sampled at grant / locked re-start)
//  rx          out  8        received byte, valid while ack high
//  ack[1:0]    out  2        one-cycle pulse to owning client: byte done
//  grant[1:0]  out  2        one-hot current owner, 0 when bus free
//  spi_cs_n    out  NUM_DEV  active-low device selects (RTC polarity inversion done at top level)
//  spi_clk     out  1        SPI clock, idle low
//  spi_mosi    out  1        SPI data out, MSB first
//  spi_miso    in   1        SPI data in
// BEHAVIOUR
//  Reset (n_reset=0 at edge): state IDLE, spi_cs_n all 1, spi_clk 0, spi_mosi 1, ack 0, grant 0,
//   rx 0, last_owner=1 (so client 0 wins first tie). Applies mid-transfer: byte abandoned, no ack.
//  States: IDLE -> SETUP -> SHIFT -> DONE -> (LOCKED | IDLE); LOCKED -> SHIFT | IDLE.
//  IDLE: if any req: owner = sole requester, or on tie the client != last_owner. Latch dev/tx,
//   set grant, assert spi_cs_n[dev]; go SETUP. dev >= NUM_DEV: no select asserted, byte still clocked.
//  SETUP: count CS_SETUP cycles, mosi = tx[7] driven; then SHIFT.
//  SHIFT: 16 half-periods of CLK_DIV cycles each. Rising edge: sample spi_miso into shift LSB.
//   Falling edge: shift left, present next bit on mosi. After 16th half-period spi_clk=0; go DONE.
//  DONE (1 cycle): ack[owner]=1, rx=received byte, last_owner=owner.
//   If lock[owner]=1 sampled this cycle -> LOCKED (select held, grant held); else deassert select,
//   grant=0, mosi=1 -> IDLE (re-arbitration possible next cycle).
//  LOCKED: req[owner]=1 -> latch tx of owner, go SHIFT directly (no SETUP); device index not re-sampled.
//   lock[owner]=0 and req[owner]=0 -> release select and grant -> IDLE. Other client's req waits.
//   req and lock both high: transfer wins. lock dropped with req high: transfer, then release at DONE.
//  Latency (unlocked): req high at edge N -> grant at N+1, ack at N+1+CS_SETUP+16*CLK_DIV+1 approx;
//   exact: ack asserted in cycle N+2+CS_SETUP+16*CLK_DIV. Locked follow-on byte: 16*CLK_DIV+2 cycles.
//  Client dropping req mid-byte: byte completes, ack still pulsed (client ignores). Non-owner req never
//   disturbs an active transfer. ack and grant never asserted for a client concurrently with the other.
//  Counters: half-period counter width clog2(CLK_DIV), bit counter 4 bits, wraps never (bounded by state).
// STRUCTURE
//  Shared package: state enum (IDLE/SETUP/SHIFT/DONE/LOCKED), device index constants DEV_MMC=0,
//   DEV_FLASH=1, DEV_RTC=2.
//  One sub-module: spi_shift_engine (divider, bit counter, mode-0 shifter; start/busy/done, tx/rx);
//   arbiter FSM, owner/round-robin and select muxing stay in spi_bus_arbiter.
// TESTING
//  1. Reset mid-SHIFT: assert n_reset=0 for 1 cycle -> next cycle cs_n=3'b111, spi_clk=0, no ack ever.
//  2. Client 0 only, dev0=0, tx0=8'hA5, MISO loopback -> cs_n=3'b110, mosi bits 1,0,1,0,0,1,0,1,
//     ack[0] exactly at cycle 2+2+64 after req (defaults), rx=8'hA5, cs_n=3'b111 next cycle.
//  3. Both req same cycle from reset -> client 0 first, then client 1 (round-robin), then with both
//     still requesting client 0 again; no overlap of grant bits.
//  4. Client 1 lock=1, dev1=2, three bytes 8'h01,8'h02,8'h03 while client 0 req held -> cs_n=3'b011
//     continuously across 3 bytes, no SETUP gap, client 0 granted only after lock[1]=0 and req[1]=0.
//  5. MISO driven from model returning 8'h3C -> rx=8'h3C sampled on rising edges, spi_clk 16 edges.
//  6. CLK_DIV=1, CS_SETUP=1 build: byte completes, ack at cycle 2+1+16 after req; dev=3 -> no select.

Source files
------------

// File: rtl/spi_bus_arbiter_pkg.sv
// Shared types for the board SPI bus arbiter: FSM states, device indices
// and the client one-hot helper.
package spi_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_DONE,
    ST_LOCKED
  } arb_state_t;

  localparam logic [1:0] DEV_MMC   = 2'd0;
  localparam logic [1:0] DEV_FLASH = 2'd1;
  localparam logic [1:0] DEV_RTC   = 2'd2;

  function automatic logic [1:0] client_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_if.sv
// Client handshake plus SPI pin bundle. The arbiter connects through the
// slave modport; the requesting side and the SPI slave model use master.
interface spi_bus_arbiter_if #(
  parameter int NUM_DEV = 3
);
  logic [1:0]         req;
  logic [1:0]         lock;
  logic [1:0]         dev0;
  logic [1:0]         dev1;
  logic [7:0]         tx0;
  logic [7:0]         tx1;
  logic [7:0]         rx;
  logic [1:0]         ack;
  logic [1:0]         grant;
  logic [NUM_DEV-1:0] spi_cs_n;
  logic               spi_clk;
  logic               spi_mosi;
  logic               spi_miso;

  modport master (
    output req, lock, dev0, dev1, tx0, tx1, spi_miso,
    input  rx, ack, grant, spi_cs_n, spi_clk, spi_mosi
  );

  modport slave (
    input  req, lock, dev0, dev1, tx0, tx1, spi_miso,
    output rx, ack, grant, spi_cs_n, spi_clk, spi_mosi
  );
endinterface

// File: rtl/spi_shift_engine.sv
// Mode-0 SPI byte shifter: clock divider, 16 half-period sequencer, MSB-first
// shift register. A start pulse loads tx; done pulses once the last falling edge is out.
module spi_shift_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic       sysclk,
  input  logic       n_reset,
  input  logic       start,
  input  logic [7:0] tx,
  input  logic       preset,
  input  logic       preset_bit,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic [3:0]    half_cnt;
  logic [7:0]    shreg;
  logic          miso_q;

  assign rx = shreg;

  // NOTE: non-blocking throughout, so spi_clk, shreg and mosi all advance from pre-edge values.
  always_ff @(posedge sysclk) begin
    if (!n_reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b1;
      div_cnt  <= '0;
      half_cnt <= '0;
      shreg    <= '0;
      miso_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy     <= 1'b1;
        shreg    <= tx;
        spi_mosi <= tx[7];
        spi_clk  <= 1'b0;
        div_cnt  <= '0;
        half_cnt <= '0;
      end else if (busy) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt  <= '0;
          spi_clk  <= ~spi_clk;
          half_cnt <= half_cnt + 4'd1;
          // Rising edge captures miso; the following falling edge commits it and presents the next bit.
          if (!spi_clk) begin
            miso_q <= spi_miso;
          end else begin
            shreg    <= {shreg[6:0], miso_q};
            spi_mosi <= shreg[6];
          end
          if (half_cnt == 4'd15) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end else if (preset) begin
        spi_mosi <= preset_bit;
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one SPI bus between the control CPU (client 0) and the Amiga side (client 1):
// round-robin per transaction, optional lock to hold the select across multi-byte frames.
module spi_bus_arbiter #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int NUM_DEV  = 3
) (
  input  logic           sysclk,
  input  logic           n_reset,
  spi_bus_arbiter_if.slave bus
);
  import spi_bus_arbiter_pkg::*;

  localparam int            SW         = (CS_SETUP > 1) ? $clog2(CS_SETUP) : 1;
  localparam logic [SW-1:0] SETUP_LAST = SW'(CS_SETUP - 1);

  arb_state_t         state;
  logic               owner;
  logic               last_owner;
  logic [1:0]         grant_q;
  logic [1:0]         ack_q;
  logic [7:0]         rx_q;
  logic [7:0]         tx_q;
  logic [NUM_DEV-1:0] cs_n_q;
  logic [SW-1:0]      setup_cnt;

  logic               pick;
  logic [1:0]         pick_dev;
  logic [7:0]         pick_tx;
  logic [7:0]         own_tx;
  logic               own_req;
  logic               own_lock;
  logic [NUM_DEV-1:0] sel_n;

  logic               eng_start;
  logic               eng_busy;
  logic               eng_done;
  logic               eng_preset;
  logic               eng_preset_bit;
  logic [7:0]         eng_tx;
  logic [7:0]         eng_rx;
  logic               eng_clk;
  logic               eng_mosi;

  // NOTE: every always_comb output gets a default first, so no case path can infer a latch.
  always_comb begin
    // Client 1 wins if alone, or on a tie when client 0 owned the bus last.
    pick     = bus.req[1] & (~bus.req[0] | ~last_owner);
    pick_dev = pick ? bus.dev1 : bus.dev0;
    pick_tx  = pick ? bus.tx1  : bus.tx0;
    own_tx   = owner ? bus.tx1 : bus.tx0;
    own_req  = bus.req[owner];
    own_lock = bus.lock[owner];

    sel_n = '1;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (int'(pick_dev) == i) sel_n[i] = 1'b0;
    end

    eng_start      = 1'b0;
    eng_tx         = tx_q;
    eng_preset     = 1'b0;
    eng_preset_bit = 1'b1;
    case (state)
      ST_IDLE: begin
        eng_preset     = |bus.req;
        eng_preset_bit = pick_tx[7];
      end
      ST_SETUP:  eng_start = !eng_busy && (setup_cnt == SETUP_LAST);
      ST_LOCKED: begin
        eng_start = !eng_busy && own_req;
        eng_tx    = own_tx;
      end
      ST_DONE:   eng_preset = !own_lock;
      default:   ;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (!n_reset) begin
      state      <= ST_IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      grant_q    <= '0;
      ack_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      cs_n_q     <= '1;
      setup_cnt  <= '0;
    end else begin
      ack_q <= '0;
      unique case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            owner     <= pick;
            grant_q   <= client_onehot(pick);
            tx_q      <= pick_tx;
            cs_n_q    <= sel_n;
            setup_cnt <= '0;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (setup_cnt == SETUP_LAST) state <= ST_SHIFT;
          else                         setup_cnt <= setup_cnt + 1'b1;
        end
        ST_SHIFT: begin
          if (eng_done) begin
            ack_q      <= client_onehot(owner);
            rx_q       <= eng_rx;
            last_owner <= owner;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (own_lock) begin
            state <= ST_LOCKED;
          end else begin
            cs_n_q  <= '1;
            grant_q <= '0;
            state   <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          // A pending byte beats a lock release; the other client waits either way.
          if (own_req) begin
            tx_q  <= own_tx;
            state <= ST_SHIFT;
          end else if (!own_lock) begin
            cs_n_q  <= '1;
            grant_q <= '0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .sysclk     (sysclk),
    .n_reset    (n_reset),
    .start      (eng_start),
    .tx         (eng_tx),
    .preset     (eng_preset),
    .preset_bit (eng_preset_bit),
    .busy       (eng_busy),
    .done       (eng_done),
    .rx         (eng_rx),
    .spi_clk    (eng_clk),
    .spi_mosi   (eng_mosi),
    .spi_miso   (bus.spi_miso)
  );

  assign bus.rx       = rx_q;
  assign bus.ack      = ack_q;
  assign bus.grant    = grant_q;
  assign bus.spi_cs_n = cs_n_q;
  assign bus.spi_clk  = eng_clk;
  assign bus.spi_mosi = eng_mosi;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed + randomized bench for spi_bus_arbiter: a default build and a
// CLK_DIV=1/CS_SETUP=1 build, checked against a transaction-level model.
module tb_spi_bus_arbiter;
  import spi_bus_arbiter_pkg::*;

  localparam int DIV   = 4;
  localparam int CSU   = 2;
  localparam int DIV_F = 1;
  localparam int CSU_F = 1;

  logic sysclk = 1'b0;
  logic n_reset;
  always #5 sysclk = ~sysclk;

  spi_bus_arbiter_if #(.NUM_DEV(3)) bus ();
  spi_bus_arbiter_if #(.NUM_DEV(3)) bus_f ();

  spi_bus_arbiter #(.CLK_DIV(DIV), .CS_SETUP(CSU), .NUM_DEV(3)) u_dut (
    .sysclk  (sysclk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  spi_bus_arbiter #(.CLK_DIV(DIV_F), .CS_SETUP(CSU_F), .NUM_DEV(3)) u_dut_fast (
    .sysclk  (sysclk),
    .n_reset (n_reset),
    .bus     (bus_f)
  );

  int checks = 0;
  int errors = 0;

  // SPI slave model: loopback, or a fixed byte presented MSB first, advancing on falling spi_clk.
  int         rise_cnt = 0;
  int         fall_cnt = 0;
  int         rise_base;
  int         fall_base;
  logic       mosi_log [0:1023];
  logic       loopback;
  logic [7:0] miso_byte;
  logic [2:0] miso_idx;

  always @(posedge bus.spi_clk) begin
    mosi_log[rise_cnt % 1024] = bus.spi_mosi;
    rise_cnt++;
  end
  always @(negedge bus.spi_clk) fall_cnt++;

  assign miso_idx      = 3'(7 - (fall_cnt - fall_base));
  assign bus.spi_miso  = loopback ? bus.spi_mosi : miso_byte[miso_idx];
  assign bus_f.spi_miso = bus_f.spi_mosi;

  int ack0_cnt = 0;
  int ack1_cnt = 0;
  int overlap_err = 0;
  always @(negedge sysclk) begin
    if (bus.grant == 2'b11 || bus.ack == 2'b11 || (bus.ack & ~bus.grant) != 2'b00) overlap_err++;
    if (bus.ack[0]) ack0_cnt++;
    if (bus.ack[1]) ack1_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    @(negedge sysclk);
  endtask

  task automatic do_reset();
    bus.req = 2'b00;
    bus.lock = 2'b00;
    n_reset = 1'b0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    n_reset = 1'b1;
  endtask

  // Model of one unlocked byte on the default build with only client c requesting.
  task automatic run_byte(input int c, input logic [1:0] d, input logic [7:0] t,
                          input logic lb, input logic [7:0] mb, input string tag);
    int         cyc;
    logic [2:0] exp_cs;
    logic [7:0] exp_rx;
    logic [7:0] got;
    exp_cs    = (d < 2'd3) ? ~(3'b001 << d) : 3'b111;
    exp_rx    = lb ? t : mb;
    loopback  = lb;
    miso_byte = mb;
    if (c == 0) begin bus.dev0 = d; bus.tx0 = t; end
    else        begin bus.dev1 = d; bus.tx1 = t; end
    rise_base = rise_cnt;
    fall_base = fall_cnt;
    bus.req[c] = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
      if (cyc == 1) begin
        check({tag, "_grant"}, 32'(bus.grant), 32'(2'b01 << c));
        check({tag, "_cs"}, 32'(bus.spi_cs_n), 32'(exp_cs));
      end
    end while (!bus.ack[c] && cyc < 400);
    check({tag, "_latency"}, 32'(cyc), 32'(2 + CSU + 16 * DIV));
    check({tag, "_rx"}, 32'(bus.rx), 32'(exp_rx));
    check({tag, "_rises"}, 32'(rise_cnt - rise_base), 32'd8);
    check({tag, "_falls"}, 32'(fall_cnt - fall_base), 32'd8);
    check({tag, "_clk_idle"}, 32'(bus.spi_clk), 32'd0);
    for (int i = 0; i < 8; i++) got[7-i] = mosi_log[(rise_base + i) % 1024];
    check({tag, "_mosi"}, 32'(got), 32'(t));
    bus.req[c] = 1'b0;
    tick();
    check({tag, "_cs_release"}, 32'(bus.spi_cs_n), 32'h7);
    check({tag, "_grant_release"}, 32'(bus.grant), 32'd0);
  endtask

  initial begin
    int         cyc;
    int         a0;
    int         a1;
    int         model_last;
    int         exp_owner;
    logic       held_ok;
    logic       cs_ok;
    logic [7:0] t;
    logic [1:0] d;
    logic [2:0] exp_cs;

    bus.req = 2'b00; bus.lock = 2'b00;
    bus.dev0 = DEV_MMC; bus.dev1 = DEV_MMC; bus.tx0 = 8'h00; bus.tx1 = 8'h00;
    bus_f.req = 2'b00; bus_f.lock = 2'b00;
    bus_f.dev0 = DEV_MMC; bus_f.dev1 = DEV_MMC; bus_f.tx0 = 8'h00; bus_f.tx1 = 8'h00;
    loopback = 1'b1; miso_byte = 8'h00; rise_base = 0; fall_base = 0;
    n_reset = 1'b0;
    @(negedge sysclk);
    do_reset();

    check("reset_cs", 32'(bus.spi_cs_n), 32'h7);
    check("reset_clk", 32'(bus.spi_clk), 32'd0);
    check("reset_mosi", 32'(bus.spi_mosi), 32'd1);
    check("reset_ack", 32'(bus.ack), 32'd0);
    check("reset_grant", 32'(bus.grant), 32'd0);
    check("reset_rx", 32'(bus.rx), 32'd0);

    // Single byte, client 0, MMC, loopback.
    run_byte(0, DEV_MMC, 8'hA5, 1'b1, 8'h00, "c0_a5");

    // Reset while the byte is mid-shift: abandoned, never acknowledged.
    bus.dev0 = DEV_FLASH; bus.tx0 = 8'h5A; bus.req[0] = 1'b1;
    repeat (20) tick();
    a0 = ack0_cnt; a1 = ack1_cnt;
    n_reset = 1'b0; bus.req = 2'b00;
    tick();
    n_reset = 1'b1;
    check("midrst_cs", 32'(bus.spi_cs_n), 32'h7);
    check("midrst_clk", 32'(bus.spi_clk), 32'd0);
    check("midrst_mosi", 32'(bus.spi_mosi), 32'd1);
    check("midrst_grant", 32'(bus.grant), 32'd0);
    repeat (100) tick();
    check("midrst_no_ack", 32'((ack0_cnt - a0) + (ack1_cnt - a1)), 32'd0);

    // Slave returns 8'h3C regardless of mosi.
    run_byte(1, DEV_FLASH, 8'h96, 1'b0, 8'h3C, "c1_3c");

    for (int k = 0; k < 6; k++) begin
      run_byte(int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom),
               1'($urandom_range(0, 1)), 8'($urandom), "rand");
    end

    // Both clients request from reset and keep requesting: round robin from last_owner=1.
    do_reset();
    bus.dev0 = DEV_FLASH; bus.dev1 = DEV_MMC;
    bus.tx0 = 8'($urandom); bus.tx1 = 8'($urandom);
    loopback = 1'b1;
    model_last = 1;
    bus.req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      exp_owner = 1 - model_last;
      cyc = 0;
      do begin tick(); cyc++; end while (bus.grant == 2'b00 && cyc < 20);
      check("rr_grant", 32'(bus.grant), 32'(1 << exp_owner));
      cyc = 0;
      do begin tick(); cyc++; end while (bus.ack == 2'b00 && cyc < 400);
      check("rr_ack", 32'(bus.ack), 32'(1 << exp_owner));
      model_last = exp_owner;
      if (k == 2) bus.req = 2'b00;
      tick();
      check("rr_release", 32'(bus.grant), 32'd0);
    end

    // Locked three-byte frame on client 1 (RTC) while client 0 waits.
    bus.dev1 = DEV_RTC; bus.tx1 = 8'h01; bus.lock[1] = 1'b1; bus.req[1] = 1'b1;
    bus.dev0 = DEV_MMC; bus.tx0 = 8'h5A;
    cyc = 0;
    do begin tick(); cyc++; end while (bus.grant == 2'b00 && cyc < 20);
    check("lock_grant", 32'(bus.grant), 32'h2);
    bus.req[0] = 1'b1;
    held_ok = 1'b1;
    for (int b = 0; b < 3; b++) begin
      cyc = 0;
      do begin
        tick();
        cyc++;
        if (bus.spi_cs_n !== 3'b011 || bus.grant !== 2'b10) held_ok = 1'b0;
      end while (!bus.ack[1] && cyc < 400);
      check("lock_rx", 32'(bus.rx), 32'(b + 1));
      // Ack to ack: one LOCKED cycle then the follow-on byte of 16*CLK_DIV+2.
      if (b > 0) check("lock_interval", 32'(cyc), 32'(16 * DIV + 3));
      if (b < 2) bus.tx1 = 8'(b + 2);
      else begin bus.req[1] = 1'b0; bus.lock[1] = 1'b0; end
    end
    check("lock_held", 32'(held_ok), 32'd1);
    cyc = 0;
    do begin tick(); cyc++; end while (bus.grant == 2'b00 && cyc < 20);
    check("lock_handover_cycles", 32'(cyc), 32'd2);
    check("lock_handover_grant", 32'(bus.grant), 32'h1);
    check("lock_handover_cs", 32'(bus.spi_cs_n), 32'h6);
    cyc = 0;
    do begin tick(); cyc++; end while (!bus.ack[0] && cyc < 400);
    check("lock_c0_rx", 32'(bus.rx), 32'h5A);
    bus.req[0] = 1'b0;
    tick();
    check("grant_overlap", 32'(overlap_err), 32'd0);

    // Minimal-timing build: one byte with no select, one on RTC.
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 2'd3 : DEV_RTC;
      t = 8'($urandom);
      exp_cs = (k == 0) ? 3'b111 : 3'b011;
      bus_f.dev1 = d; bus_f.tx1 = t; bus_f.req[1] = 1'b1;
      cs_ok = 1'b1;
      cyc = 0;
      do begin
        tick();
        cyc++;
        if (bus_f.spi_cs_n !== exp_cs) cs_ok = 1'b0;
      end while (!bus_f.ack[1] && cyc < 100);
      check("fast_latency", 32'(cyc), 32'(2 + CSU_F + 16 * DIV_F));
      check("fast_rx", 32'(bus_f.rx), 32'(t));
      check("fast_cs", 32'(cs_ok), 32'd1);
      bus_f.req[1] = 1'b0;
      tick();
      check("fast_release", 32'(bus_f.spi_cs_n), 32'h7);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
